bbox_issue_ctl: RTL and testbench

- Upstream driver for the black-box vector personality (bbox_box_top via its wrapper). The personality starts one element every clock and has a fixed latency.
- Accepts operand requests on a valid/ready interface, registers them onto the va/vb/scalar/arc0 operand bus, and tracks in-flight slots with a valid/tag delay line.
- Captures the vt/vm results into a response FIFO. Issue is credit-throttled so no result is ever dropped.

---
 rtl/bbox_issue_if.sv | 54 +++++
 rtl/bbox_issue_ctl.sv | 192 +++++++++++++++++++
 tb/tb_bbox_issue_ctl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bbox_issue_if.sv
// bbox_issue_if: request, bbox operand/result and response signals of bbox_issue_ctl.
//
// Groups:
//   request  : i_req_vld/o_req_rdy handshake with tag, A, B, scalar and arc0 operands
//   bbox bus : o_va/o_vb/o_scalar/o_arc0/o_issue to the personality, i_vt/i_vm back
//   response : o_rsp_vld/i_rsp_rdy handshake with data, tag and match flag
//   status   : o_inflight, o_idle
// Modports: slave is the controller side; master is the requester/bbox/consumer side.
// TAG_W and FIFO_DEPTH must match the values given to bbox_issue_ctl.
interface bbox_issue_if #(
    parameter int unsigned TAG_W      = 8,
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic             i_req_vld;
    logic             o_req_rdy;
    logic [TAG_W-1:0] i_req_tag;
    logic [63:0]      i_req_a;
    logic [63:0]      i_req_b;
    logic [63:0]      i_req_scalar;
    logic [11:0]      i_req_arc0;

    logic [63:0]      o_va;
    logic [63:0]      o_vb;
    logic [63:0]      o_scalar;
    logic [11:0]      o_arc0;
    logic             o_issue;
    logic [63:0]      i_vt;
    logic             i_vm;

    logic             o_rsp_vld;
    logic             i_rsp_rdy;
    logic [63:0]      o_rsp_data;
    logic [TAG_W-1:0] o_rsp_tag;
    logic             o_rsp_vm;

    logic [CntW-1:0]  o_inflight;
    logic             o_idle;

    modport slave (
        input  i_req_vld, i_req_tag, i_req_a, i_req_b, i_req_scalar, i_req_arc0,
        input  i_vt, i_vm, i_rsp_rdy,
        output o_req_rdy, o_va, o_vb, o_scalar, o_arc0, o_issue,
        output o_rsp_vld, o_rsp_data, o_rsp_tag, o_rsp_vm, o_inflight, o_idle
    );

    modport master (
        output i_req_vld, i_req_tag, i_req_a, i_req_b, i_req_scalar, i_req_arc0,
        output i_vt, i_vm, i_rsp_rdy,
        input  o_req_rdy, o_va, o_vb, o_scalar, o_arc0, o_issue,
        input  o_rsp_vld, o_rsp_data, o_rsp_tag, o_rsp_vm, o_inflight, o_idle
    );
endinterface

// File: rtl/bbox_issue_ctl.sv
// bbox_issue_ctl: upstream driver for the black-box vector personality.
//
// Accepts tagged operand requests, registers them onto the bbox operand bus (one slot per
// clock), tracks each slot's {valid, tag} through a PIPE_LAT-deep delay line aligned with
// the bbox result, and captures valid results into a first-word-fall-through response FIFO.
// Issue is credit-throttled on (in-flight + FIFO occupancy) so a capture never finds the
// FIFO full.
//
// Ports:
//   intfClk1x     sole clock
//   reset_n       synchronous active-low reset
//   bus           bbox_issue_if.slave (request, bbox operand/result, response, status)
//   o_stat_issued accepted-request counter, saturating   (BBOX_ISSUE_STATS_EN only)
//   o_stat_stall  cycles with a request held off, saturating (BBOX_ISSUE_STATS_EN only)
//
// Optional feature: define BBOX_ISSUE_STATS_EN to add the two statistics counters.
// PIPE_LAT must be >= 2; FIFO_DEPTH must be a power of two and >= PIPE_LAT+2.
module bbox_issue_ctl #(
    parameter int unsigned PIPE_LAT   = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TAG_W      = 8
) (
    input  logic        intfClk1x,
    input  logic        reset_n,
`ifdef BBOX_ISSUE_STATS_EN
    output logic [31:0] o_stat_issued,
    output logic [31:0] o_stat_stall,
`endif
    bbox_issue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [63:0]      data;
        logic             vm;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    // Operand bus registers
    logic [63:0]      va_q, vb_q, scalar_q;
    logic [11:0]      arc0_q;
    logic             issue_q;
    logic [TAG_W-1:0] issue_tag_q;

    // Slot tracking delay line; the last stage lines up with i_vt/i_vm
    logic [PIPE_LAT-1:0] dl_vld_q;
    logic [TAG_W-1:0]    dl_tag_q [PIPE_LAT];

    // Response FIFO
    rsp_t            mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CntW-1:0] inflight_q, inflight_d;

    logic [CntW:0] credit_used;
    logic          req_rdy;
    logic          accept;
    logic          capture;
    logic          rsp_vld;
    logic          pop;

    // Both credit terms are registered, so ready never depends on this cycle's handshakes
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign req_rdy     = reset_n && (credit_used < DepthC);
    assign accept      = bus.i_req_vld && req_rdy;
    assign capture     = dl_vld_q[PIPE_LAT-1];
    assign rsp_vld     = (fifo_cnt_q != '0);
    assign pop         = rsp_vld && bus.i_rsp_rdy;

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !capture) begin
            inflight_d = inflight_q + CntW'(1);
        end else if (!accept && capture) begin
            inflight_d = inflight_q - CntW'(1);
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (capture && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CntW'(1);
        end else if (!capture && pop) begin
            fifo_cnt_d = fifo_cnt_q - CntW'(1);
        end
    end

    // Idle slots drive zero operands; the bbox still runs them but their results are dropped
    always_ff @(posedge intfClk1x) begin
        if (!reset_n) begin
            va_q        <= '0;
            vb_q        <= '0;
            scalar_q    <= '0;
            arc0_q      <= '0;
            issue_q     <= 1'b0;
            issue_tag_q <= '0;
        end else if (accept) begin
            va_q        <= bus.i_req_a;
            vb_q        <= bus.i_req_b;
            scalar_q    <= bus.i_req_scalar;
            arc0_q      <= bus.i_req_arc0;
            issue_q     <= 1'b1;
            issue_tag_q <= bus.i_req_tag;
        end else begin
            va_q        <= '0;
            vb_q        <= '0;
            scalar_q    <= '0;
            arc0_q      <= '0;
            issue_q     <= 1'b0;
            issue_tag_q <= '0;
        end
    end

    // Stage 0 loads from the operand-bus slot, so stage PIPE_LAT-1 holds the slot whose
    // operands were on the bus PIPE_LAT cycles ago, matching the bbox result.
    always_ff @(posedge intfClk1x) begin
        if (!reset_n) begin
            dl_vld_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_tag_q[i] <= '0;
            end
        end else begin
            dl_vld_q    <= {dl_vld_q[PIPE_LAT-2:0], issue_q};
            dl_tag_q[0] <= issue_tag_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_tag_q[i] <= dl_tag_q[i-1];
            end
        end
    end

    // Storage only; occupancy is tracked by the pointers and count, so no reset is needed
    always_ff @(posedge intfClk1x) begin
        if (reset_n && capture) begin
            mem_q[wr_ptr_q] <= '{data: bus.i_vt, vm: bus.i_vm, tag: dl_tag_q[PIPE_LAT-1]};
        end
    end

    always_ff @(posedge intfClk1x) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            inflight_q <= '0;
        end else begin
            if (capture) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            fifo_cnt_q <= fifo_cnt_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef BBOX_ISSUE_STATS_EN
    logic [31:0] stat_issued_q, stat_stall_q;

    always_ff @(posedge intfClk1x) begin
        if (!reset_n) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (accept && (stat_issued_q != '1)) begin
                stat_issued_q <= stat_issued_q + 32'd1;
            end
            if (bus.i_req_vld && !req_rdy && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign o_stat_issued = stat_issued_q;
    assign o_stat_stall  = stat_stall_q;
`endif

    assign bus.o_req_rdy  = req_rdy;
    assign bus.o_va       = va_q;
    assign bus.o_vb       = vb_q;
    assign bus.o_scalar   = scalar_q;
    assign bus.o_arc0     = arc0_q;
    assign bus.o_issue    = issue_q;
    assign bus.o_rsp_vld  = rsp_vld;
    assign bus.o_rsp_data = mem_q[rd_ptr_q].data;
    assign bus.o_rsp_tag  = mem_q[rd_ptr_q].tag;
    assign bus.o_rsp_vm   = mem_q[rd_ptr_q].vm;
    assign bus.o_inflight = inflight_q;
    assign bus.o_idle     = (inflight_q == '0) && (fifo_cnt_q == '0);

endmodule

// File: tb/tb_bbox_issue_ctl.sv
// tb_bbox_issue_ctl: scoreboard bench for bbox_issue_ctl with a PIPE_LAT-deep bbox model
// (vt = va + vb, vm = va == vb). Inputs change 1 time unit after a rising edge; outputs
// are sampled on the falling edge.
module tb_bbox_issue_ctl;
    localparam int unsigned PIPE_LAT   = 8;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned TAG_W      = 8;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  tag;
        logic        vm;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    int   checks   = 0;
    int   failures = 0;
    int   resp_cnt = 0;
    exp_t sb [$];

    bbox_issue_if #(.TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

`ifdef BBOX_ISSUE_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_stall;
`endif

    bbox_issue_ctl #(
        .PIPE_LAT  (PIPE_LAT),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TAG_W     (TAG_W)
    ) dut (
        .intfClk1x    (clk),
        .reset_n      (reset_n),
`ifdef BBOX_ISSUE_STATS_EN
        .o_stat_issued(stat_issued),
        .o_stat_stall (stat_stall),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Bbox model: fixed-latency pipe, never reset
    logic [63:0] m_vt [PIPE_LAT] = '{default: '0};
    logic        m_vm [PIPE_LAT] = '{default: 1'b0};

    always @(posedge clk) begin
        m_vt[0] <= bus.o_va + bus.o_vb;
        m_vm[0] <= (bus.o_va == bus.o_vb);
        for (int i = 1; i < PIPE_LAT; i++) begin
            m_vt[i] <= m_vt[i-1];
            m_vm[i] <= m_vm[i-1];
        end
    end

    assign bus.i_vt = m_vt[PIPE_LAT-1];
    assign bus.i_vm = m_vm[PIPE_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at edge+1; offers one request for one cycle, returns at the next edge+1
    task automatic offer(input logic [7:0] tag, input logic [63:0] a, input logic [63:0] b,
                         output bit acc);
        exp_t e;
        bus.i_req_vld    = 1'b1;
        bus.i_req_tag    = tag;
        bus.i_req_a      = a;
        bus.i_req_b      = b;
        bus.i_req_scalar = a ^ 64'h5555;
        bus.i_req_arc0   = {4'hA, tag};
        @(negedge clk);
        acc = bus.o_req_rdy;
        if (acc) begin
            e.data = a + b;
            e.tag  = tag;
            e.vm   = (a == b);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.i_req_vld = 1'b0;
    endtask

    // Monitor: every response handshake is compared against the scoreboard head
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && bus.o_rsp_vld && bus.i_rsp_rdy) begin
                resp_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got tag 0x%0h data 0x%0h, none expected",
                             bus.o_rsp_tag, bus.o_rsp_data);
                end else begin
                    e = sb.pop_front();
                    check("rsp_tag", 64'(bus.o_rsp_tag), 64'(e.tag));
                    check("rsp_data", bus.o_rsp_data, e.data);
                    check("rsp_vm", 64'(bus.o_rsp_vm), 64'(e.vm));
                end
            end
        end
    end

    // A capture must never land in a full FIFO
    initial begin : overflow_watch
        forever begin
            @(negedge clk);
            if (reset_n && dut.dl_vld_q[PIPE_LAT-1] && (dut.fifo_cnt_q == FIFO_DEPTH)) begin
                failures++;
                $display("FAIL fifo_overflow: capture with count %0d, required < %0d",
                         dut.fifo_cnt_q, FIFO_DEPTH);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit acc;
        int n_acc;
        int base;
`ifdef BBOX_ISSUE_STATS_EN
        logic [31:0] iss_base, stl_base;
`endif
        reset_n          = 1'b0;
        bus.i_req_vld    = 1'b0;
        bus.i_req_tag    = '0;
        bus.i_req_a      = '0;
        bus.i_req_b      = '0;
        bus.i_req_scalar = '0;
        bus.i_req_arc0   = '0;
        bus.i_rsp_rdy    = 1'b0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_req_rdy", 64'(bus.o_req_rdy), 64'd0);
        check("rst_issue", 64'(bus.o_issue), 64'd0);
        check("rst_va", bus.o_va, 64'd0);
        check("rst_rsp_vld", 64'(bus.o_rsp_vld), 64'd0);
        check("rst_inflight", 64'(bus.o_inflight), 64'd0);
        check("rst_idle", 64'(bus.o_idle), 64'd1);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_rdy", 64'(bus.o_req_rdy), 64'd1);
        tick();

        // Single op: accept at edge k, response valid after edge k+9
        offer(8'h11, 64'd3, 64'd5, acc);
        check("single_acc", 64'(acc), 64'd1);
        @(negedge clk);
        check("single_va", bus.o_va, 64'd3);
        check("single_vb", bus.o_vb, 64'd5);
        check("single_scalar", bus.o_scalar, 64'h5556);
        check("single_arc0", 64'(bus.o_arc0), 64'hA11);
        check("single_issue", 64'(bus.o_issue), 64'd1);
        check("single_inflight", 64'(bus.o_inflight), 64'd1);
        check("single_idle", 64'(bus.o_idle), 64'd0);
        for (int i = 1; i <= PIPE_LAT; i++) begin
            tick();
            @(negedge clk);
            check("single_early_vld", 64'(bus.o_rsp_vld), 64'd0);
            if (i == 1) check("single_issue_off", 64'(bus.o_issue), 64'd0);
        end
        tick();
        @(negedge clk);
        check("single_vld", 64'(bus.o_rsp_vld), 64'd1);
        check("single_data", bus.o_rsp_data, 64'd8);
        check("single_tag", 64'(bus.o_rsp_tag), 64'h11);
        check("single_vm", 64'(bus.o_rsp_vm), 64'd0);
        check("single_inflight_0", 64'(bus.o_inflight), 64'd0);
        tick();
        bus.i_rsp_rdy = 1'b1;
        tick();
        @(negedge clk);
        check("single_idle_after_pop", 64'(bus.o_idle), 64'd1);
        check("single_vld_after_pop", 64'(bus.o_rsp_vld), 64'd0);
        tick();

        // Back-pressure: 20 offers with no consumer, only 16 fit
        bus.i_rsp_rdy = 1'b0;
        n_acc = 0;
`ifdef BBOX_ISSUE_STATS_EN
        iss_base = stat_issued;
        stl_base = stat_stall;
`endif
        for (int t = 0; t < 20; t++) begin
            offer(8'(t), 64'(t), 64'd100, acc);
            check("bp_rdy", 64'(acc), (t < 16) ? 64'd1 : 64'd0);
            if (acc) n_acc++;
        end
        check("bp_accepted", 64'(n_acc), 64'd16);
        repeat (12) tick();
        @(negedge clk);
        check("bp_rdy_full", 64'(bus.o_req_rdy), 64'd0);
        check("bp_inflight", 64'(bus.o_inflight), 64'd0);
        check("bp_rsp_vld", 64'(bus.o_rsp_vld), 64'd1);
`ifdef BBOX_ISSUE_STATS_EN
        check("stat_issued", 64'(stat_issued - iss_base), 64'd16);
        check("stat_stall", 64'(stat_stall - stl_base), 64'd4);
`endif
        base = resp_cnt;
        tick();
        bus.i_rsp_rdy = 1'b1;
        @(negedge clk);
        check("bp_rdy_before_pop", 64'(bus.o_req_rdy), 64'd0);
        tick();
        @(negedge clk);
        check("bp_rdy_recover", 64'(bus.o_req_rdy), 64'd1);
        repeat (20) tick();
        check("bp_drained", 64'(resp_cnt - base), 64'd16);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Streaming: 100 back-to-back requests with a ready consumer
        base = resp_cnt;
        for (int i = 0; i < 100; i++) begin
            offer(8'(i), 64'(i), 64'(i), acc);
            check("stream_rdy", 64'(acc), 64'd1);
        end
        repeat (15) tick();
        check("stream_count", 64'(resp_cnt - base), 64'd100);
        check("stream_sb_empty", 64'(sb.size()), 64'd0);

        // Boundary: credit at 15, accept and pop on the same edge
        bus.i_rsp_rdy = 1'b0;
        base = resp_cnt;
        for (int i = 0; i < 15; i++) begin
            offer(8'(8'h40 + i), 64'(i), 64'd1, acc);
        end
        repeat (12) tick();
        @(negedge clk);
        check("bnd_inflight_0", 64'(bus.o_inflight), 64'd0);
        check("bnd_rdy_at_15", 64'(bus.o_req_rdy), 64'd1);
        tick();
        bus.i_rsp_rdy = 1'b1;
        offer(8'h60, 64'd7, 64'd7, acc);
        bus.i_rsp_rdy = 1'b0;
        check("bnd_acc", 64'(acc), 64'd1);
        @(negedge clk);
        check("bnd_rdy_hold", 64'(bus.o_req_rdy), 64'd1);
        check("bnd_inflight_1", 64'(bus.o_inflight), 64'd1);
        repeat (PIPE_LAT + 2) tick();
        @(negedge clk);
        check("bnd_rdy_settled", 64'(bus.o_req_rdy), 64'd1);
        check("bnd_inflight_settled", 64'(bus.o_inflight), 64'd0);
        tick();
        offer(8'h61, 64'd9, 64'd2, acc);
        check("bnd_last_acc", 64'(acc), 64'd1);
        @(negedge clk);
        check("bnd_rdy_at_16", 64'(bus.o_req_rdy), 64'd0);
        tick();
        bus.i_rsp_rdy = 1'b1;
        repeat (30) tick();
        check("bnd_count", 64'(resp_cnt - base), 64'd17);
        check("bnd_sb_empty", 64'(sb.size()), 64'd0);

        // Reset mid-operation: 3 responses queued, 5 ops in flight
        bus.i_rsp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) offer(8'(8'h80 + i), 64'(i), 64'd4, acc);
        repeat (12) tick();
        for (int i = 0; i < 5; i++) offer(8'(8'h90 + i), 64'(i), 64'd6, acc);
        @(negedge clk);
        check("mid_inflight", 64'(bus.o_inflight), 64'd5);
        tick();
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_rdy_forced", 64'(bus.o_req_rdy), 64'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_va", bus.o_va, 64'd0);
        check("mid_rst_issue", 64'(bus.o_issue), 64'd0);
        check("mid_rst_inflight", 64'(bus.o_inflight), 64'd0);
        check("mid_rst_rsp_vld", 64'(bus.o_rsp_vld), 64'd0);
        check("mid_rst_idle", 64'(bus.o_idle), 64'd1);
        check("mid_rst_rdy", 64'(bus.o_req_rdy), 64'd1);
        tick();
        bus.i_rsp_rdy = 1'b1;
        for (int i = 0; i < PIPE_LAT + 2; i++) begin
            @(negedge clk);
            check("mid_no_rsp", 64'(bus.o_rsp_vld), 64'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
